// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one four-bank main memory between the instruction-cache controller
//   (I port) and the data-cache controller (D port). At most one operation is
//   issued per cycle. A bank that is still busy is never issued to. Ties are
//   broken round-robin. Read data is steered back to the port that issued the
//   read by a tag pipeline whose depth matches the memory read latency.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_rd / i_wr       I-port read / write request (level, held until accept)
//   i_addr, i_wdata   I-port address and write data
//   i_accept          pulse: I request issued this cycle
//   i_rvalid, i_rdata pulse + data: read data returned to the I port
//   i_err             pulse: I port presented rd and wr together (rejected)
//   d_*               same set of signals for the D port
//   mem_rd, mem_wr    memory read / write strobes
//   mem_addr,
//   mem_wdata         memory address and write data (0 when idle)
//   mem_data_out      memory read data, valid READ_LAT cycles after issue
//   mem_busy          per-bank busy flags reported by the memory
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 2,
    parameter int BANK_BUSY = 4,
    parameter int BANK_LSB  = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_accept,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_accept,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [3:0]        mem_busy
);

    localparam int CNT_W = $clog2(BANK_BUSY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY - 1);
    localparam int LAST = READ_LAT - 1;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0] i_bank;
    logic [1:0] d_bank;
    logic       i_req;
    logic       d_req;
    logic       i_elig;
    logic       d_elig;
    logic [3:0] bank_free;

    assign i_bank = i_addr[BANK_LSB+1:BANK_LSB];
    assign d_bank = d_addr[BANK_LSB+1:BANK_LSB];

    // Outputs are held at 0 while reset is asserted, so requests are masked.
    assign i_req = (i_rd ^ i_wr) & ~rst;
    assign d_req = (d_rd ^ d_wr) & ~rst;
    assign i_err = i_rd & i_wr & ~rst;
    assign d_err = d_rd & d_wr & ~rst;

    assign i_elig = i_req & bank_free[i_bank];
    assign d_elig = d_req & bank_free[d_bank];

    // ------------------------------------------------------------------
    // Round-robin grant. rr_i_last_q = 1 means I won the last grant, so D
    // wins the next tie. Ties are resolved purely on the pointer, even when
    // the two ports target different banks.
    // ------------------------------------------------------------------
    logic rr_i_last_q;
    logic rr_i_last_d;
    logic grant_i;
    logic grant_d;

    assign grant_i = i_elig & (~d_elig | ~rr_i_last_q);
    assign grant_d = d_elig & (~i_elig |  rr_i_last_q);

    assign i_accept = grant_i;
    assign d_accept = grant_d;

    always_comb begin
        rr_i_last_d = rr_i_last_q;
        if (grant_i) begin
            rr_i_last_d = 1'b1;
        end else if (grant_d) begin
            rr_i_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_i_last_q <= 1'b1;
        end else begin
            rr_i_last_q <= rr_i_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory command mux
    // ------------------------------------------------------------------
    logic       issue;
    logic       issue_rd;
    logic [1:0] issue_bank;

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        issue_bank = 2'd0;
        if (grant_i) begin
            mem_rd     = i_rd;
            mem_wr     = i_wr;
            mem_addr   = i_addr;
            mem_wdata  = i_wdata;
            issue_bank = i_bank;
        end else if (grant_d) begin
            mem_rd     = d_rd;
            mem_wr     = d_wr;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            issue_bank = d_bank;
        end
    end

    assign issue    = grant_i | grant_d;
    assign issue_rd = mem_rd;

    // ------------------------------------------------------------------
    // Per-bank busy counters. Loading BANK_BUSY-1 on issue and counting down
    // to 0 spaces two issues to one bank exactly BANK_BUSY cycles apart.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            localparam logic [1:0] BANK_ID = 2'(gi);
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (issue && (issue_bank == BANK_ID)) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign bank_free[gi] = (cnt_q == '0) & ~mem_busy[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-return tag pipeline: stage k holds {valid, port} for a read issued
    // k+1 cycles ago; port bit is 1 for D. The last stage lines up with
    // mem_data_out.
    // ------------------------------------------------------------------
    logic [READ_LAT-1:0] tag_v_q;
    logic [READ_LAT-1:0] tag_v_d;
    logic [READ_LAT-1:0] tag_p_q;
    logic [READ_LAT-1:0] tag_p_d;

    always_comb begin
        tag_v_d    = '0;
        tag_p_d    = '0;
        tag_v_d[0] = issue & issue_rd;
        tag_p_d[0] = grant_d;
        for (int k = 1; k < READ_LAT; k++) begin
            tag_v_d[k] = tag_v_q[k-1];
            tag_p_d[k] = tag_p_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_q <= '0;
            tag_p_q <= '0;
        end else begin
            tag_v_q <= tag_v_d;
            tag_p_q <= tag_p_d;
        end
    end

    assign i_rvalid = tag_v_q[LAST] & ~tag_p_q[LAST];
    assign d_rvalid = tag_v_q[LAST] &  tag_p_q[LAST];
    assign i_rdata  = i_rvalid ? mem_data_out : '0;
    assign d_rdata  = d_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Inputs change 1 time unit after the rising
// edge; DUT outputs are checked at the falling edge. "Cycle 0" of a scenario
// is the cycle in which the first request is presented.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              i_rd;
    logic              i_wr;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_accept;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_accept;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_data_out;
    logic [3:0]        mem_busy;

    int checks_q   = 0;
    int failures_q = 0;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (2),
        .BANK_BUSY(4),
        .BANK_LSB (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rd        (i_rd),
        .i_wr        (i_wr),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_accept    (i_accept),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .i_err       (i_err),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_accept    (d_accept),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .d_err       (d_err),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_data_out(mem_data_out),
        .mem_busy    (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            failures_q++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_rd = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_busy = '0; mem_data_out = '0;
    endtask

    // Two-cycle reset; returns 1 time unit after the edge that ends it.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Per-cycle expectations for the round-robin scenario.
    logic [ADDR_W-1:0] rr_i_addr [4];
    logic [ADDR_W-1:0] rr_d_addr [4];
    logic              rr_exp_d  [4];
    logic [ADDR_W-1:0] rr_exp_adr[4];

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ---------------- reset state (request held during reset) -------
        d_rd = 1; d_addr = 16'h0010;
        i_rd = 1; i_wr = 1;
        sample();
        chk("rst_d_accept", 32'(d_accept), 32'd0);
        chk("rst_mem_rd",   32'(mem_rd),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_i_err",    32'(i_err),    32'd0);
        chk("rst_rvalid",   32'({i_rvalid, d_rvalid}), 32'd0);

        // ---------------- 1: single D read ------------------------------
        do_reset();
        d_rd = 1; d_addr = 16'h0010;
        sample();
        chk("t1_c0_d_accept", 32'(d_accept), 32'd1);
        chk("t1_c0_i_accept", 32'(i_accept), 32'd0);
        chk("t1_c0_mem_rd",   32'(mem_rd),   32'd1);
        chk("t1_c0_mem_wr",   32'(mem_wr),   32'd0);
        chk("t1_c0_mem_addr", 32'(mem_addr), 32'h0010);
        next_cycle();
        d_rd = 0;
        sample();
        chk("t1_c1_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        next_cycle();
        mem_data_out = 16'hBEEF;
        sample();
        chk("t1_c2_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("t1_c2_d_rdata",  32'(d_rdata),  32'hBEEF);
        chk("t1_c2_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("t1_c2_i_rdata",  32'(i_rdata),  32'd0);
        next_cycle();
        mem_data_out = '0;
        sample();
        chk("t1_c3_d_rvalid", 32'(d_rvalid), 32'd0);

        // ---------------- 2: simultaneous reads, D wins first -----------
        do_reset();
        i_rd = 1; i_addr = 16'h0002;
        d_rd = 1; d_addr = 16'h0004;
        sample();
        chk("t2_c0_d_accept", 32'(d_accept), 32'd1);
        chk("t2_c0_i_accept", 32'(i_accept), 32'd0);
        chk("t2_c0_mem_addr", 32'(mem_addr), 32'h0004);
        next_cycle();
        d_rd = 0;
        sample();
        chk("t2_c1_i_accept", 32'(i_accept), 32'd1);
        chk("t2_c1_mem_addr", 32'(mem_addr), 32'h0002);
        chk("t2_c1_rvalid",   32'({i_rvalid, d_rvalid}), 32'd0);
        next_cycle();
        i_rd = 0;
        mem_data_out = 16'h1111;
        sample();
        chk("t2_c2_rvalid", 32'({i_rvalid, d_rvalid}), 32'b01);
        chk("t2_c2_d_rdata", 32'(d_rdata), 32'h1111);
        next_cycle();
        mem_data_out = 16'h2222;
        sample();
        chk("t2_c3_rvalid", 32'({i_rvalid, d_rvalid}), 32'b10);
        chk("t2_c3_i_rdata", 32'(i_rdata), 32'h2222);
        chk("t2_c3_d_rdata", 32'(d_rdata), 32'h0000);

        // ---------------- 3: back-to-back writes to bank 0 --------------
        do_reset();
        d_wr = 1; d_addr = 16'h0000; d_wdata = 16'hA5A5;
        sample();
        chk("t3_c0_d_accept",  32'(d_accept),  32'd1);
        chk("t3_c0_mem_wr",    32'(mem_wr),    32'd1);
        chk("t3_c0_mem_wdata", 32'(mem_wdata), 32'hA5A5);
        next_cycle();
        d_addr = 16'h0008; d_wdata = 16'h5A5A;
        for (int c = 1; c <= 3; c++) begin
            sample();
            chk($sformatf("t3_c%0d_mem_wr", c),   32'(mem_wr),   32'd0);
            chk($sformatf("t3_c%0d_d_accept", c), 32'(d_accept), 32'd0);
            next_cycle();
        end
        sample();
        chk("t3_c4_d_accept",  32'(d_accept),  32'd1);
        chk("t3_c4_mem_wr",    32'(mem_wr),    32'd1);
        chk("t3_c4_mem_addr",  32'(mem_addr),  32'h0008);
        chk("t3_c4_mem_wdata", 32'(mem_wdata), 32'h5A5A);
        next_cycle();
        d_wr = 0;

        // ---------------- 4: continuous contention, alternating ---------
        // cycle: I addr (bank)  D addr (bank)  winner
        //   0    0002 (1)       0000 (0)       D
        //   1    0002 (1)       0004 (2)       I
        //   2    0006 (3)       0004 (2)       D
        //   3    0006 (3)       0016 (3)       I  (same bank, pointer decides)
        rr_i_addr = '{16'h0002, 16'h0002, 16'h0006, 16'h0006};
        rr_d_addr = '{16'h0000, 16'h0004, 16'h0004, 16'h0016};
        rr_exp_d  = '{1'b1, 1'b0, 1'b1, 1'b0};
        rr_exp_adr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            i_rd = 1; i_addr = rr_i_addr[c];
            d_rd = 1; d_addr = rr_d_addr[c];
            sample();
            chk($sformatf("t4_c%0d_d_accept", c), 32'(d_accept), 32'(rr_exp_d[c]));
            chk($sformatf("t4_c%0d_i_accept", c), 32'(i_accept), 32'(!rr_exp_d[c]));
            chk($sformatf("t4_c%0d_mem_addr", c), 32'(mem_addr), 32'(rr_exp_adr[c]));
            next_cycle();
        end
        idle_inputs();

        // ---------------- 5: illegal D request, legal I request ---------
        do_reset();
        d_rd = 1; d_wr = 1; d_addr = 16'h0004;
        i_rd = 1; i_addr = 16'h0002;
        sample();
        chk("t5_c0_d_err",    32'(d_err),    32'd1);
        chk("t5_c0_d_accept", 32'(d_accept), 32'd0);
        chk("t5_c0_i_accept", 32'(i_accept), 32'd1);
        chk("t5_c0_mem_rdwr", 32'({mem_rd, mem_wr}), 32'b10);
        chk("t5_c0_mem_addr", 32'(mem_addr), 32'h0002);
        chk("t5_c0_i_err",    32'(i_err),    32'd0);
        next_cycle();
        i_rd = 0;
        sample();
        chk("t5_c1_d_err",    32'(d_err),    32'd1);
        chk("t5_c1_d_accept", 32'(d_accept), 32'd0);
        chk("t5_c1_mem_rdwr", 32'({mem_rd, mem_wr}), 32'b00);
        next_cycle();
        d_rd = 0; d_wr = 0;
        sample();
        chk("t5_c2_d_err", 32'(d_err), 32'd0);

        // ---------------- 6: reset mid-operation ------------------------
        do_reset();
        d_rd = 1; d_addr = 16'h0010;
        sample();
        chk("t6_c0_d_accept", 32'(d_accept), 32'd1);
        next_cycle();
        d_rd = 0;
        rst = 1'b1;
        mem_data_out = 16'hDEAD;
        sample();
        chk("t6_c1_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            sample();
            chk($sformatf("t6_c%0d_rvalid", c), 32'({i_rvalid, d_rvalid}), 32'd0);
            next_cycle();
        end
        // Memory reports bank 0 busy: D (bank 0) blocked, I (bank 1) goes.
        mem_busy = 4'b0001;
        d_rd = 1; d_addr = 16'h0000;
        i_rd = 1; i_addr = 16'h0002;
        sample();
        chk("t6_busy_d_accept", 32'(d_accept), 32'd0);
        chk("t6_busy_i_accept", 32'(i_accept), 32'd1);
        chk("t6_busy_mem_addr", 32'(mem_addr), 32'h0002);
        next_cycle();
        i_rd = 0;
        mem_busy = 4'b0000;
        sample();
        chk("t6_free_d_accept", 32'(d_accept), 32'd1);
        chk("t6_free_mem_addr", 32'(mem_addr), 32'h0000);
        next_cycle();
        idle_inputs();
        sample();
        chk("t6_i_rvalid_after", 32'({i_rvalid, d_rvalid}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
